// File: rtl/reg_dump_ctrl.sv
// Register-file dump sequencer: after HALT, waits for writebacks to drain, then reads
// r0..r(NUM_REGS-1) over the halt read port and streams each value out on a
// valid/ready handshake.
module reg_dump_ctrl #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hlt,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] reg_data,
    output logic              re_hlt,
    output logic [ADDR_W-1:0] addr_hlt,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0]   DrainMax = CntW'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StRead,
        StCapture,
        StPresent,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;

    // State, counters and the presented beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            idx_q       <= '0;
            dump_data_q <= '0;
            dump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
            dump_addr_q <= dump_addr_d;
        end
    end

    // Next-state sequencing: drain, then READ/CAPTURE/PRESENT per register.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        dump_addr_d = dump_addr_q;
        unique case (state_q)
            StIdle: begin
                if (hlt) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainMax;
                end
            end
            StDrain: begin
                // Any writeback restarts the quiet window.
                if (wb_we) begin
                    drain_cnt_d = DrainMax;
                end else if (drain_cnt_q == '0) begin
                    state_d = StRead;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            StRead: begin
                state_d = StCapture;
            end
            StCapture: begin
                // BRAM data for the address presented in READ is valid now.
                dump_data_d = reg_data;
                dump_addr_d = idx_q;
                state_d     = StPresent;
            end
            StPresent: begin
                if (dump_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state or taken straight from registers.
    always_comb begin
        busy       = (state_q == StDrain) || (state_q == StRead) ||
                     (state_q == StCapture) || (state_q == StPresent);
        re_hlt     = busy;
        // DRAIN parks the mux on address 0; afterwards it follows the index.
        addr_hlt   = ((state_q == StRead) || (state_q == StCapture) ||
                      (state_q == StPresent)) ? idx_q : '0;
        dump_valid = (state_q == StPresent);
        done       = (state_q == StDone);
        dump_data  = dump_data_q;
        dump_addr  = dump_addr_q;
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: behavioural register file with 1-cycle read latency, a
// scoreboard queue filled by the stimulus and drained by a handshake monitor.
module tb_reg_dump_ctrl;

    logic        clk;
    logic        rst_n;
    logic        hlt;
    logic        wb_we;
    logic [31:0] reg_data;
    logic        re_hlt;
    logic [4:0]  addr_hlt;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_addr;
    logic        busy;
    logic        done;

    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        preload;
    logic [31:0] rf [32];

    logic [36:0] exp_q [$];
    int          checks;
    int          errors;

    reg_dump_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hlt        (hlt),
        .wb_we      (wb_we),
        .reg_data   (reg_data),
        .re_hlt     (re_hlt),
        .addr_hlt   (addr_hlt),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_addr  (dump_addr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write port, S-port read with one cycle latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
        end else if (wb_we) begin
            rf[wb_addr] <= wb_data;
        end
        if (re_hlt) reg_data <= rf[addr_hlt];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=addr %0d data %h required=none",
                         dump_addr, dump_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("beat_addr", 32'(dump_addr), 32'(e[36:32]));
                check("beat_data", dump_data, e[31:0]);
            end
        end
    end

    task automatic push_default(input logic [4:0] patch_addr, input logic [31:0] patch_data,
                                input bit patch);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] d;
            d = 32'h100 + 32'(i);
            if (patch && (5'(i) == patch_addr)) d = patch_data;
            exp_q.push_back({5'(i), d});
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        hlt        = 1'b0;
        wb_we      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        dump_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_preload();
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check(name, 32'(done), 32'd1);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_re_hlt"}, 32'(re_hlt), 32'd0);
        check({name, "_addr_hlt"}, 32'(addr_hlt), 32'd0);
        check({name, "_dump_valid"}, 32'(dump_valid), 32'd0);
        check({name, "_dump_data"}, dump_data, 32'd0);
        check({name, "_dump_addr"}, 32'(dump_addr), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        preload = 1'b0;

        // Reset state.
        do_reset();
        check_all_zero("reset");
        do_preload();

        // 1: full dump, ready tied high; first beat at T+6.
        push_default(5'd0, 32'd0, 1'b0);
        #1 hlt = 1'b1;
        @(posedge clk);            // T
        #1 hlt = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_re_hlt", 32'(re_hlt), 32'd1);
        repeat (5) @(posedge clk); // T+5
        #1 check("t1_valid_early", 32'(dump_valid), 32'd0);
        @(posedge clk);            // T+6
        #1 check("t1_valid_first", 32'(dump_valid), 32'd1);
        wait_done("t1_done");

        // 2: backpressure on beat 3.
        do_reset();
        push_default(5'd0, 32'd0, 1'b0);
        hlt = 1'b1;
        @(posedge clk);
        #1 hlt = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (dump_valid && dump_addr == 5'd2) break;
        end
        @(posedge clk);            // beat 2 accepted here
        #1 dump_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dump_valid) break;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(dump_valid), 32'd1);
            check("t2_hold_addr", 32'(dump_addr), 32'd3);
            check("t2_hold_data", dump_data, 32'h103);
            @(posedge clk);
            #1;
        end
        dump_ready = 1'b1;
        wait_done("t2_done");

        // 3: writeback during DRAIN restarts the wait and updates r5.
        do_reset();
        push_default(5'd5, 32'hDEAD, 1'b1);
        hlt = 1'b1;
        @(posedge clk);            // T
        #1 hlt = 1'b0;
        repeat (2) @(posedge clk); // T+2
        #1 begin
            wb_we   = 1'b1;
            wb_addr = 5'd5;
            wb_data = 32'hDEAD;
        end
        @(posedge clk);            // T+3: drain counter reloaded
        #1 wb_we = 1'b0;
        repeat (5) @(posedge clk); // T+8
        #1 check("t3_valid_delayed", 32'(dump_valid), 32'd0);
        @(posedge clk);            // T+9
        #1 check("t3_valid_first", 32'(dump_valid), 32'd1);
        wait_done("t3_done");

        // 4: reset during beat 10, then a fresh dump from address 0.
        do_reset();
        do_preload();
        push_default(5'd0, 32'd0, 1'b0);
        hlt = 1'b1;
        @(posedge clk);
        #1 hlt = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (dump_valid && dump_addr == 5'd10) break;
        end
        check("t4_reached_beat10", 32'(dump_addr), 32'd10);
        rst_n = 1'b0;
        #1 check_all_zero("t4_async_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_default(5'd0, 32'd0, 1'b0);
        hlt = 1'b1;
        @(posedge clk);
        #1 hlt = 1'b0;
        wait_done("t4_done");

        // 5: hlt held into DRAIN then dropped; dump still completes.
        do_reset();
        push_default(5'd0, 32'd0, 1'b0);
        hlt = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 hlt = 1'b0;
        wait_done("t5_done");

        // 6: hlt in DONE is ignored; any beat here trips the monitor.
        hlt = 1'b1;
        repeat (3) @(posedge clk);
        #1 hlt = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_done_sticky", 32'(done), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_re_hlt", 32'(re_hlt), 32'd0);
        check("t6_valid", 32'(dump_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
